// File: rtl/rip_gshare_predictor.sv
// Gshare branch direction predictor: PC xor speculative global history
// indexes a table of saturating counters, swept to INIT_CTR after reset.
module rip_gshare_predictor #(
  parameter int INDEX_WIDTH = 10,
  parameter int HISTORY_LEN = 8,
  parameter int CTR_WIDTH   = 2,
  parameter int PC_LSB      = 2,
  parameter int INIT_CTR    = 2 ** (CTR_WIDTH - 1)
) (
  input  logic                   clk,
  input  logic                   rstn,
  output logic                   init_done,
  input  logic                   pred_valid,
  output logic                   pred_ready,
  input  logic [31:0]            pc,
  output logic                   pred_out_valid,
  output logic                   pred_taken,
  output logic [INDEX_WIDTH-1:0] pred_index,
  output logic [CTR_WIDTH-1:0]   pred_ctr,
  output logic [HISTORY_LEN-1:0] pred_history,
  input  logic                   upd_valid,
  input  logic [INDEX_WIDTH-1:0] upd_index,
  input  logic [CTR_WIDTH-1:0]   upd_ctr,
  input  logic [HISTORY_LEN-1:0] upd_history,
  input  logic                   upd_taken,
  input  logic                   upd_mispredict
);

  localparam int DEPTH = 1 << INDEX_WIDTH;

  typedef enum logic {
    INIT,
    READY
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [INDEX_WIDTH-1:0] init_addr;
  logic [INDEX_WIDTH-1:0] init_addr_nxt;
  logic [CTR_WIDTH-1:0]   table_q [DEPTH];
  logic [HISTORY_LEN-1:0] spec_hist;
  logic [HISTORY_LEN-1:0] hist_nxt;
  logic [HISTORY_LEN:0]   shift_cat;
  logic [HISTORY_LEN:0]   rec_cat;
  logic [INDEX_WIDTH-1:0] rd_idx;
  logic [CTR_WIDTH-1:0]   upd_ctr_nxt;
  logic                   accept;
  logic                   recover;
  logic                   issue;
  logic                   wr_en;
  logic [INDEX_WIDTH-1:0] wr_addr;
  logic [CTR_WIDTH-1:0]   wr_data;
  logic                   unused_bits;

  assign init_done  = (state == READY);
  assign pred_ready = init_done;
  assign pred_taken = pred_ctr[CTR_WIDTH-1];

  assign accept  = pred_valid & pred_ready;
  assign recover = init_done & upd_valid & upd_mispredict;
  assign issue   = accept & ~recover;

  assign rd_idx = pc[PC_LSB +: INDEX_WIDTH]
                ^ INDEX_WIDTH'(spec_hist);

  // One extra bit so the shift also works for HISTORY_LEN == 1.
  assign shift_cat = {spec_hist, pred_taken};
  assign rec_cat   = {upd_history, upd_taken};

  assign unused_bits = ^{pc, shift_cat[HISTORY_LEN],
                         rec_cat[HISTORY_LEN]};

  always_comb begin
    state_nxt     = state;
    init_addr_nxt = init_addr;
    case (state)
      INIT: begin
        init_addr_nxt = init_addr + 1'b1;
        if (init_addr == '1)
          state_nxt = READY;
      end
      READY: ;
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    upd_ctr_nxt = upd_ctr;
    unique case (1'b1)
      upd_taken && (upd_ctr != '1):
        upd_ctr_nxt = upd_ctr + 1'b1;
      !upd_taken && (upd_ctr != '0):
        upd_ctr_nxt = upd_ctr - 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = upd_index;
    wr_data = upd_ctr_nxt;
    if (state == INIT) begin
      wr_en   = rstn;
      wr_addr = init_addr;
      wr_data = CTR_WIDTH'(INIT_CTR);
    end else begin
      wr_en = rstn & upd_valid;
    end
  end

  always_comb begin
    hist_nxt = spec_hist;
    if (recover)
      hist_nxt = rec_cat[HISTORY_LEN-1:0];
    else if (pred_out_valid)
      hist_nxt = shift_cat[HISTORY_LEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      table_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state          <= INIT;
      init_addr      <= '0;
      spec_hist      <= '0;
      pred_out_valid <= 1'b0;
      pred_index     <= '0;
      pred_ctr       <= '0;
      pred_history   <= '0;
    end else begin
      state          <= state_nxt;
      init_addr      <= init_addr_nxt;
      spec_hist      <= hist_nxt;
      pred_out_valid <= issue;
      if (issue) begin
        pred_index   <= rd_idx;
        pred_ctr     <= table_q[rd_idx];
        pred_history <= spec_hist;
      end
    end
  end

endmodule

// File: doc/rip_gshare_predictor.md
RIP_GSHARE_PREDICTOR -- requirements
Module: rip_gshare_predictor

Interface
REQ-001 Parameter INDEX_WIDTH, default 10, sets the table depth to 2^INDEX_WIDTH entries.
REQ-002 Parameter HISTORY_LEN, default 8, sets the global history bits; legal range 1..INDEX_WIDTH.
REQ-003 Parameter CTR_WIDTH, default 2, sets the saturating counter width; legal range 2..4.
REQ-004 Parameter PC_LSB, default 2, is the lowest PC bit used for indexing.
REQ-005 Parameter INIT_CTR, default 2^(CTR_WIDTH-1) (weakly taken), is the counter value written during init.
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 rstn  in  1  reset, synchronous, active-low.
REQ-008 init_done  out  1  table initialisation complete.
REQ-009 pred_valid  in  1  prediction request.
REQ-010 pred_ready  out  1  request accepted when pred_valid & pred_ready.
REQ-011 pc  in  32  PC of the requesting branch.
REQ-012 pred_out_valid  out  1  prediction result valid.
REQ-013 pred_taken  out  1  predicted direction.
REQ-014 pred_index  out  INDEX_WIDTH  table index used.
REQ-015 pred_ctr  out  CTR_WIDTH  counter value read.
REQ-016 pred_history  out  HISTORY_LEN  speculative history snapshot used to form the index.
REQ-017 upd_valid  in  1  branch resolution.
REQ-018 upd_index, upd_ctr, upd_history  in  INDEX_WIDTH/CTR_WIDTH/HISTORY_LEN  values carried back from the prediction.
REQ-019 upd_taken  in  1  actual direction.
REQ-020 upd_mispredict  in  1  resolution disagreed with the prediction; qualified by upd_valid.

Function
REQ-021 FSM states SHALL be INIT and READY; reset enters INIT with init address 0.
REQ-022 INIT SHALL write INIT_CTR to address 0,1,...,2^INDEX_WIDTH-1 on consecutive cycles, then move to READY; the address wraps to 0 at the transition.
REQ-023 init_done SHALL be 1 only in READY; pred_ready SHALL equal init_done.
REQ-024 In INIT, pred_valid and upd_valid SHALL be ignored, with no table write and no history change.
REQ-025 Index SHALL be pc[PC_LSB+INDEX_WIDTH-1:PC_LSB] XOR zero-extended spec_hist, computed in the accept cycle.
REQ-026 Table read latency SHALL be 1 cycle: pred_out_valid, pred_ctr, pred_index and pred_history are registered in the cycle after accept.
REQ-027 pred_taken SHALL equal pred_ctr MSB.
REQ-028 In the pred_out_valid cycle, spec_hist SHALL become {spec_hist[HISTORY_LEN-2:0], pred_taken} (just pred_taken when HISTORY_LEN=1).
REQ-029 Back-to-back accepts SHALL use spec_hist as registered; a request accepted in the cycle after another does not yet see that prediction's bit.
REQ-030 On upd_valid, the table entry upd_index SHALL be written with upd_ctr+1 if upd_taken, else upd_ctr-1, saturating at 2^CTR_WIDTH-1 and 0.
REQ-031 On upd_valid & upd_mispredict, spec_hist SHALL load {upd_history[HISTORY_LEN-2:0], upd_taken}.
REQ-032 Recovery SHALL take priority over the REQ-028 shift in the same cycle.
REQ-033 A request accepted in a recovery cycle SHALL be squashed: pred_out_valid stays 0 next cycle and there is no history shift.
REQ-034 A read and a write to the same address in one cycle SHALL return the old data (read-first).
REQ-035 upd_valid without upd_mispredict SHALL NOT alter spec_hist.

Reset
REQ-036 When rstn=0 at a clock edge: state INIT, init address 0, spec_hist 0, pred_out_valid 0, pred_taken 0, pred_index 0, pred_ctr 0, pred_history 0, init_done 0.
REQ-037 Reset mid-INIT or mid-READY SHALL restart the full init sweep; table contents are not preserved.

Verification
REQ-038 rstn high from edge 0, defaults -> init_done=0 for 1024 cycles and 1 from cycle 1024; a pred_valid held during INIT produces no pred_out_valid.
REQ-039 After init, pc=0x100 request -> one cycle later pred_out_valid=1, pred_index=0x040, pred_ctr=2, pred_taken=1, pred_history=0; spec_hist then becomes 0x01.
REQ-040 Update index 0x040 with upd_ctr=3 and upd_taken=1 -> next read gives 3 (saturates); upd_ctr=0 with upd_taken=0 -> 0; upd_ctr=2 with upd_taken=0 -> 1 and pred_taken=0.
REQ-041 spec_hist=0xAB, upd_valid=1, upd_mispredict=1, upd_history=0x0F, upd_taken=0 -> spec_hist=0x1E; a request accepted that same cycle gives pred_out_valid=0 next cycle.
REQ-042 Same-cycle update write and request read of index 0x040 -> pred_ctr shows the old value; a request one cycle later shows the new value.
REQ-043 rstn pulsed low mid-stream, with in-flight prediction and spec_hist=0x55 -> outputs and spec_hist are 0 and the 1024-cycle init repeats before pred_ready=1.
